dvi_tmds_encoder: RTL
=====================

# dvi_tmds_encoder

Three-channel DVI 1.0 TMDS encoder that sits directly downstream of the test-pattern/timing generator in the video path. It takes the 8-bit R/G/B pixel bus plus DE/HS/VS, all launched on the pixel clock, and produces three 10-bit TMDS characters per pixel clock. Its output feeds the 10:1 serializers and the differential output buffers.

## Interface
- Parameters: none.
- `I_pxl_clk` input 1: pixel clock. All logic is on the rising edge.
- `I_rst` input 1: asynchronous, active-high reset.
- `I_de` input 1: data enable. 1 = active pixel, 0 = blanking.
- `I_hs` input 1: horizontal sync, already at final polarity.
- `I_vs` input 1: vertical sync, already at final polarity.
- `I_data_r` input 8: red pixel component.
- `I_data_g` input 8: green pixel component.
- `I_data_b` input 8: blue pixel component.
- `O_tmds_ch0` output 10: blue channel character. Carries C0=`I_hs`, C1=`I_vs` during blanking.
- `O_tmds_ch1` output 10: green channel character. C1C0=00 during blanking.
- `O_tmds_ch2` output 10: red channel character. C1C0=00 during blanking.
- Bit 0 of each character is transmitted first.

## Operation
- Three identical channel instances. Each instance has its own disparity counter `cnt`: 5-bit signed two's complement, held within −8..+8.
- Notation: N1(x) = ones count of x; N0 = 8 − N1.
- **Stage 1 (register inputs):** register D, DE and C1C0, and compute N1(D).
- **Stage 2 (build q_m):**
  - Use XNOR when N1(D) > 4, or when N1(D) == 4 and D[0] == 0. Otherwise use XOR.
  - q_m[0] = D[0]; q_m[i] = q_m[i−1] op D[i] for i = 1..7.
  - q_m[8] = 0 for XNOR, 1 for XOR.
  - Register q_m and N1(q_m[7:0]).
- **Stage 3, DE = 1 (data characters):**
  - **Case A: cnt == 0 or N1 == N0.**
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1 − N0) : (N0 − N1).
  - **Case B: (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1).**
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (N0 − N1).
  - **Case C: otherwise.**
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += (N1 − N0) − 2·(~q_m[8]).
- **Stage 3, DE = 0 (control characters):**
  - cnt ← 0.
  - out is the control token selected by C1C0:
    - 00 → 1101010100
    - 01 → 0010101011
    - 10 → 0101010100
    - 11 → 1010101011
- cnt arithmetic is performed at 6-bit signed width and truncated to 5 bits. The bounded algorithm guarantees that truncation never loses information.
- No handshake. One character per channel per clock, continuously.

## Timing
- Latency is exactly 3 clocks from input sample to `O_tmds_chN`, for both data and control paths.
- DE, HS and VS are pipelined alongside the data, so control/data alignment is preserved.
- On `I_rst` assertion, asynchronously and mid-line included:
  - all pipeline registers clear;
  - cnt = 0;
  - every `O_tmds_chN` = 1101010100.
- While reset is held, outputs stay 1101010100.
- After release, the first sampled input appears at the outputs on the 3rd rising edge.
- DE toggling on consecutive clocks (single-pixel lines or gaps) is legal:
  - every DE = 0 cycle zeroes cnt;
  - the next DE = 1 pixel encodes from cnt = 0.
- HS/VS changes while DE = 1 are ignored for ch0 encoding. C1C0 is used only when DE = 0.

## Structure
- Shared package `dvi_pkg` holds:
  - the four control-token constants;
  - the reset token;
  - the pipeline latency constant (3), so the serializer wrapper can align.
- Sub-module `tmds_channel` contains the full 3-stage encoder for one channel: inputs clk, rst, de, c[1:0], d[7:0]; output q[9:0].
- Top level instantiates `tmds_channel` three times:
  - ch0 is driven with c = {I_vs, I_hs};
  - ch1 and ch2 are driven with c = 2'b00.
- Top level has no other logic.

## Test plan
- **Reset:** assert `I_rst` mid-frame with DE = 1 → all outputs 1101010100 immediately and held; after release, a blanking input with hs = 1, vs = 1 gives ch0 = 1010101011 and ch1/ch2 = 1101010100 on the 3rd edge.
- **Blanking tokens:** DE = 0; step {vs,hs} through 00/01/10/11 → ch0 = 1101010100/0010101011/0101010100/1010101011, each 3 clocks after its input; ch1/ch2 stay 1101010100.
- **Zero stream:** DE = 1, B = 0x00 for 3 consecutive pixels from cnt = 0 → ch0 = 0100000000 (cnt −8), 1111111111 (cnt +2), 0100000000 (cnt −6).
- **All-ones:** B = 0xFF as first pixel after blanking → ch0 = 1000000000 and cnt = −8.
- **DE gap:** pixel 0x00, one DE = 0 clock, pixel 0x00 → both data characters = 0100000000, because cnt is reset by the gap.
- **Random frame:** a full 1280×720 colour-bar frame from the timing generator compared against a reference-model TMDS encoder → bit-exact output on all channels; |cnt| ≤ 8 at all times.

Source files
------------

// File: rtl/dvi_pkg.sv
//==============================================================================
// dvi_pkg : shared TMDS constants and encoder helper functions
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package dvi_pkg;

   localparam logic [9:0] C_TOKEN_00  = 10'b1101010100;
   localparam logic [9:0] C_TOKEN_01  = 10'b0010101011;
   localparam logic [9:0] C_TOKEN_10  = 10'b0101010100;
   localparam logic [9:0] C_TOKEN_11  = 10'b1010101011;
   localparam logic [9:0] C_TOKEN_RST = C_TOKEN_00;
   localparam int         C_LATENCY   = 3;

   function automatic logic [3:0] ones8(input logic [7:0] x);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, x[i]};
      end
      return n;
   endfunction

   // Transition-minimised word; bit 8 records whether XOR (1) or XNOR (0) was used.
   function automatic logic [8:0] tmds_qm(input logic [7:0] d, input logic [3:0] n1);
      logic       use_xnor;
      logic [8:0] qm;
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      qm       = '0;
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) begin
         qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      end
      qm[8] = ~use_xnor;
      return qm;
   endfunction

   function automatic logic [9:0] ctrl_token(input logic [1:0] c);
      logic [9:0] t;
      case (c)
         2'b00:   t = C_TOKEN_00;
         2'b01:   t = C_TOKEN_01;
         2'b10:   t = C_TOKEN_10;
         default: t = C_TOKEN_11;
      endcase
      return t;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_channel.sv
//==============================================================================
// tmds_channel : three-stage DVI TMDS encoder for one colour channel
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tmds_channel
   import dvi_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       de,
   input  logic [1:0] c,
   input  logic [7:0] d,
   output logic [9:0] q
);

   logic [7:0] d1_q,    d1_d;
   logic       de1_q,   de1_d;
   logic [1:0] c1_q,    c1_d;
   logic [3:0] n1d1_q,  n1d1_d;
   logic [8:0] qm2_q,   qm2_d;
   logic [3:0] n1qm2_q, n1qm2_d;
   logic       de2_q,   de2_d;
   logic [1:0] c2_q,    c2_d;
   logic [9:0] tmds_q,  tmds_d;
   logic [4:0] cnt_q,   cnt_d;

   logic signed [5:0] cnt6;
   logic signed [5:0] diff;      // N1 - N0 of q_m[7:0]
   logic signed [5:0] qm8_x2;
   logic signed [5:0] nqm8_x2;
   logic              case_a;
   logic              case_b;

   always_comb begin
      d1_d    = d;
      de1_d   = de;
      c1_d    = c;
      n1d1_d  = ones8(d);

      qm2_d   = tmds_qm(d1_q, n1d1_q);
      n1qm2_d = ones8(qm2_d[7:0]);
      de2_d   = de1_q;
      c2_d    = c1_q;

      cnt6    = $signed({cnt_q[4], cnt_q});
      diff    = $signed({1'b0, n1qm2_q, 1'b0}) - 6'sd8;
      qm8_x2  = $signed({4'b0000, qm2_q[8], 1'b0});
      nqm8_x2 = $signed({4'b0000, ~qm2_q[8], 1'b0});
      case_a  = (cnt_q == 5'd0) || (n1qm2_q == 4'd4);
      case_b  = (!cnt_q[4] && (cnt_q != 5'd0) && (n1qm2_q > 4'd4)) ||
                ( cnt_q[4] && (n1qm2_q < 4'd4));

      if (!de2_q) begin
         tmds_d = ctrl_token(c2_q);
         cnt_d  = 5'd0;
      end else if (case_a) begin
         tmds_d = {~qm2_q[8], qm2_q[8], qm2_q[8] ? qm2_q[7:0] : ~qm2_q[7:0]};
         cnt_d  = qm2_q[8] ? 5'(cnt6 + diff) : 5'(cnt6 - diff);
      end else if (case_b) begin
         tmds_d = {1'b1, qm2_q[8], ~qm2_q[7:0]};
         cnt_d  = 5'(cnt6 + qm8_x2 - diff);
      end else begin
         tmds_d = {1'b0, qm2_q[8], qm2_q[7:0]};
         cnt_d  = 5'(cnt6 + diff - nqm8_x2);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1_q    <= '0;
         de1_q   <= 1'b0;
         c1_q    <= '0;
         n1d1_q  <= '0;
         qm2_q   <= '0;
         n1qm2_q <= '0;
         de2_q   <= 1'b0;
         c2_q    <= '0;
         tmds_q  <= C_TOKEN_RST;
         cnt_q   <= '0;
      end else begin
         d1_q    <= d1_d;
         de1_q   <= de1_d;
         c1_q    <= c1_d;
         n1d1_q  <= n1d1_d;
         qm2_q   <= qm2_d;
         n1qm2_q <= n1qm2_d;
         de2_q   <= de2_d;
         c2_q    <= c2_d;
         tmds_q  <= tmds_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q = tmds_q;

endmodule

`default_nettype wire

// File: rtl/dvi_tmds_encoder.sv
//==============================================================================
// dvi_tmds_encoder : three-channel DVI TMDS encoder (ch0 blue, ch1 green, ch2 red)
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module dvi_tmds_encoder
   import dvi_pkg::*;
(
   input  logic       I_pxl_clk,
   input  logic       I_rst,
   input  logic       I_de,
   input  logic       I_hs,
   input  logic       I_vs,
   input  logic [7:0] I_data_r,
   input  logic [7:0] I_data_g,
   input  logic [7:0] I_data_b,
   output logic [9:0] O_tmds_ch0,
   output logic [9:0] O_tmds_ch1,
   output logic [9:0] O_tmds_ch2
);

   // Only the blue channel carries sync during blanking.
   tmds_channel u_ch0 (
      .clk (I_pxl_clk),
      .rst (I_rst),
      .de  (I_de),
      .c   ({I_vs, I_hs}),
      .d   (I_data_b),
      .q   (O_tmds_ch0)
   );

   tmds_channel u_ch1 (
      .clk (I_pxl_clk),
      .rst (I_rst),
      .de  (I_de),
      .c   (2'b00),
      .d   (I_data_g),
      .q   (O_tmds_ch1)
   );

   tmds_channel u_ch2 (
      .clk (I_pxl_clk),
      .rst (I_rst),
      .de  (I_de),
      .c   (2'b00),
      .d   (I_data_r),
      .q   (O_tmds_ch2)
   );

endmodule

`default_nettype wire
